// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command port; one transaction in flight, read data/timeout routed to the issuer.
// Grant appears one cycle after IDLE sees req_vld; cmd_vld_out holds until cmd_rdy_in, responses pulse one cycle after read_rdy_in/timeout.
module uart_cmd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_vld,
    input  logic [N_REQ*CMD_WIDTH-1:0]   req_cmd,
    output logic [N_REQ-1:0]             req_rdy,
    output logic [N_REQ-1:0]             rsp_vld,
    output logic [READ_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic [CMD_WIDTH-1:0]         cmd_out,
    output logic                         cmd_vld_out,
    input  logic                         cmd_rdy_in,
    input  logic                         read_rdy_in,
    input  logic [READ_WIDTH-1:0]        read_data_in,
    output logic                         busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT   = IW'(N_REQ - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner;
    logic [TW-1:0]        timer;

    logic [CMD_WIDTH-1:0] cmd_arr [N_REQ];
    logic                 gnt_any;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        cand;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cmd_arr[i] = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        end
    end

    // Search starts just past the last winner so every requester waits at most N_REQ grants.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!gnt_any && req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= PTR_INIT;
            owner       <= '0;
            timer       <= '0;
            req_rdy     <= '0;
            rsp_vld     <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cmd_out     <= '0;
            cmd_vld_out <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_rdy <= '0;
            rsp_vld <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        ptr         <= gnt_idx;
                        owner       <= gnt_idx;
                        cmd_out     <= cmd_arr[gnt_idx];
                        cmd_vld_out <= 1'b1;
                        req_rdy     <= N_REQ'(1) << gnt_idx;
                        state       <= ISSUE;
                        busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_rdy_in) begin
                        cmd_vld_out <= 1'b0;
                        timer       <= '0;
                        // Writes have no response phase.
                        if (cmd_out[CMD_WIDTH-1]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    timer <= timer + TW'(1);
                    if (read_rdy_in) begin
                        rsp_vld  <= N_REQ'(1) << owner;
                        rsp_data <= read_data_in;
                        rsp_err  <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        rsp_vld  <= N_REQ'(1) << owner;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed bench for uart_cmd_arbiter (N_REQ=4, TIMEOUT=100); inputs driven and outputs sampled 1ns after clk rise.
module tb_uart_cmd_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int RW = 8;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [RW-1:0]   rsp_data;
    logic            rsp_err;
    logic [CW-1:0]   cmd_out;
    logic            cmd_vld_out;
    logic            cmd_rdy_in;
    logic            read_rdy_in;
    logic [RW-1:0]   read_data_in;
    logic            busy;

    int errors = 0;
    int checks = 0;

    uart_cmd_arbiter #(
        .N_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cmd_out(cmd_out), .cmd_vld_out(cmd_vld_out), .cmd_rdy_in(cmd_rdy_in),
        .read_rdy_in(read_rdy_in), .read_data_in(read_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [CW-1:0] c);
        req_cmd[i*CW +: CW] = c;
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        req_vld      = '0;
        req_cmd      = '0;
        cmd_rdy_in   = 1'b1;
        read_rdy_in  = 1'b0;
        read_data_in = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int bad;

        // Reset state
        do_reset;
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_cmd_out", 32'(cmd_out), 0);
        chk("rst_cmd_vld", 32'(cmd_vld_out), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single write from requester 0
        set_cmd(0, 16'h8A55);
        req_vld = 4'b0001;
        tick;
        chk("wr_req_rdy", 32'(req_rdy), 1);
        chk("wr_cmd_out", 32'(cmd_out), 'h8A55);
        chk("wr_cmd_vld", 32'(cmd_vld_out), 1);
        chk("wr_busy", 32'(busy), 1);
        req_vld = 4'b0000;
        tick;
        chk("wr_rdy_drop", 32'(req_rdy), 0);
        chk("wr_vld_drop", 32'(cmd_vld_out), 0);
        chk("wr_idle", 32'(busy), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rsp_vld !== 4'b0000) bad++;
        end
        chk("wr_no_rsp", 32'(bad), 0);

        // Round-robin over four held write requests
        do_reset;
        for (int i = 0; i < N; i++) set_cmd(i, 16'h8000 | 16'(i));
        req_vld = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick;
            chk("rr_grant", 32'(req_rdy), 32'(1) << (g % N));
            chk("rr_cmd", 32'(cmd_out), 32'h8000 | 32'(g % N));
            tick;
            chk("rr_pulse", 32'(req_rdy), 0);
        end
        req_vld = 4'b0000;
        tick;

        // Read from requester 2, data returned ten cycles after transfer
        set_cmd(2, 16'h0012);
        req_vld = 4'b0100;
        tick;
        chk("rd_grant", 32'(req_rdy), 4);
        chk("rd_cmd", 32'(cmd_out), 'h0012);
        req_vld = 4'b0000;
        tick;
        chk("rd_busy_wait", 32'(busy), 1);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick;
            if (rsp_vld !== 4'b0000) bad++;
        end
        chk("rd_no_early", 32'(bad), 0);
        read_rdy_in  = 1'b1;
        read_data_in = 8'hC3;
        tick;
        read_rdy_in  = 1'b0;
        read_data_in = 8'h00;
        chk("rd_rsp_vld", 32'(rsp_vld), 4);
        chk("rd_rsp_data", 32'(rsp_data), 'hC3);
        chk("rd_rsp_err", 32'(rsp_err), 0);
        tick;
        chk("rd_rsp_pulse", 32'(rsp_vld), 0);
        chk("rd_data_hold", 32'(rsp_data), 'hC3);

        // UART not ready for 50 cycles
        cmd_rdy_in = 1'b0;
        set_cmd(1, 16'h8123);
        req_vld = 4'b0010;
        tick;
        chk("bp_grant", 32'(req_rdy), 2);
        req_vld = 4'b0000;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (cmd_vld_out !== 1'b1 || cmd_out !== 16'h8123 || req_rdy !== 4'b0000) bad++;
        end
        chk("bp_hold", 32'(bad), 0);
        cmd_rdy_in = 1'b1;
        tick;
        chk("bp_xfer", 32'(cmd_vld_out), 0);
        chk("bp_idle", 32'(busy), 0);

        // Read timeout
        set_cmd(0, 16'h0034);
        req_vld = 4'b0001;
        tick;
        req_vld = 4'b0000;
        tick;
        n = 0;
        do begin
            tick;
            n++;
        end while (rsp_vld === 4'b0000 && n < 200);
        chk("to_latency", 32'(n), TO);
        chk("to_rsp_vld", 32'(rsp_vld), 1);
        chk("to_rsp_err", 32'(rsp_err), 1);
        chk("to_rsp_data", 32'(rsp_data), 0);

        // Read data arriving on the timeout cycle wins
        set_cmd(3, 16'h0035);
        req_vld = 4'b1000;
        tick;
        chk("tie_grant", 32'(req_rdy), 8);
        req_vld = 4'b0000;
        tick;
        bad = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick;
            if (rsp_vld !== 4'b0000) bad++;
        end
        chk("tie_no_early", 32'(bad), 0);
        read_rdy_in  = 1'b1;
        read_data_in = 8'h5A;
        tick;
        read_rdy_in  = 1'b0;
        chk("tie_rsp_vld", 32'(rsp_vld), 8);
        chk("tie_rsp_err", 32'(rsp_err), 0);
        chk("tie_rsp_data", 32'(rsp_data), 'h5A);

        // Reset during WAIT_RD drops the pending read
        set_cmd(1, 16'h0011);
        req_vld = 4'b0010;
        tick;
        req_vld = 4'b0000;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_cmd", 32'(cmd_out), 0);
        tick;
        rst_n        = 1'b1;
        read_rdy_in  = 1'b1;
        read_data_in = 8'h77;
        tick;
        read_rdy_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_vld !== 4'b0000 || busy !== 1'b0) bad++;
            tick;
        end
        chk("mid_rst_no_rsp", 32'(bad), 0);
        for (int i = 0; i < N; i++) set_cmd(i, 16'h8000 | 16'(i));
        req_vld = 4'b1111;
        tick;
        chk("mid_rst_grant0", 32'(req_rdy), 1);
        req_vld = 4'b0000;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
